// File: rtl/riscv_pkg.sv
// Shared constants and fetch-path types for the RV64 single-cycle core.
package riscv_pkg;

    localparam int XLEN        = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0033;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FQ_EMPTY,
        FQ_PARTIAL,
        FQ_FULL
    } fetch_state_t;

    function automatic fetch_state_t occ_state(
        input int unsigned level,
        input int unsigned depth
    );
        if (level == 0) return FQ_EMPTY;
        if (level >= depth) return FQ_FULL;
        return FQ_PARTIAL;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries between the PC stage and decode.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam logic [AW:0] ONE = (AW + 1)'(1);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and fetch initiator for a combinational instruction memory,
// buffering fetched words for decode behind a valid/ready handshake.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     fetch_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] pc;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;
    fetch_entry_t    entry;
    fetch_entry_t    head;
    fetch_state_t    state;

    assign imem_addr = pc;
    assign entry     = '{pc: pc, instr: imem_instr};

    assign state     = occ_state(32'(fifo_count), FIFO_DEPTH);
    assign out_valid = (state != FQ_EMPTY);
    assign out_instr = fifo_empty ? NOP_INSTR : head.instr;
    assign out_pc    = fifo_empty ? '0 : head.pc;

    // A pop frees the slot this cycle, so a full queue can still accept.
    assign pop  = out_valid && out_ready;
    assign push = fetch_en && !redirect_valid && (!fifo_full || pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc & ALIGN;
            end else if (push) begin
                pc <= pc + STEP;
            end
            if (pop && fetch_count != '1) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: the driver predicts delivered {pc, instr} pairs into a
// queue and an independent monitor compares them against the decode port.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] imem_addr;
    logic [63:0] out_pc;
    logic [31:0] imem_instr;
    logic [31:0] out_instr;
    logic [31:0] fetch_count;
    logic        out_valid;

    int vectors = 0;
    int miscompares = 0;

    fetch_entry_t exp_q[$];
    logic [63:0]  pc_m  = 64'h0;
    logic [31:0]  cnt_m = 32'h0;

    instruction_fetch_unit #(
        .XLEN       (64),
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_count    (fetch_count)
    );

    initial forever #10 clk = ~clk;

    // Behavioural memory: default program words, NOP beyond 1 KiB.
    function automatic logic [31:0] imem(input logic [63:0] a);
        if (a >= 64'h400) return 32'h0000_0033;
        case (a[9:2])
            8'd0:    return 32'h0000_0033;
            8'd1:    return 32'h0010_8093;
            8'd2:    return 32'h0020_8113;
            8'd22:   return 32'hA001_A001;
            8'd27:   return 32'hB001_B001;
            default: return {16'hC0DE, 6'b0, a[9:0]};
        endcase
    endfunction

    always_comb imem_instr = imem(imem_addr);

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: 2 ns after each falling edge, inputs and outputs are stable.
    initial forever begin
        @(negedge clk);
        #2;
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        end else begin
            chk("empty_pc", out_pc, 64'h0);
            chk("empty_instr", 64'(out_instr), 64'h33);
        end
        chk("imem_addr", imem_addr, pc_m);
        chk("fetch_count", 64'(fetch_count), 64'(cnt_m));
        if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
        end
    end

    // One cycle of stimulus, called at a falling edge; model update lands
    // after the monitor has consumed this cycle's head.
    task automatic drive(input logic fe, input logic rdy, input logic rv,
                         input logic [63:0] rpc);
        logic push_m;
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        push_m = fe && !rv &&
                 (exp_q.size() < DEPTH || (exp_q.size() != 0 && rdy));
        #2;
        if (rv) begin
            exp_q.delete();
            pc_m = rpc & ~64'h3;
        end else if (push_m) begin
            exp_q.push_back('{pc: pc_m, instr: imem(pc_m)});
            pc_m = pc_m + 64'd4;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, released on the next falling edge.
    task automatic pulse_reset();
        #4;
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_count", 64'(fetch_count), 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        exp_q.delete();
        pc_m  = 64'h0;
        cnt_m = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;

        repeat (2) @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t1_pc0", out_pc, 64'h0);
        chk("t1_instr0", 64'(out_instr), 64'h0000_0033);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t1_pc1", out_pc, 64'h4);
        chk("t1_instr1", 64'(out_instr), 64'h0010_8093);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t1_pc2", out_pc, 64'h8);
        chk("t1_instr2", 64'(out_instr), 64'h0020_8113);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t1_count", 64'(fetch_count), 64'd3);

        pulse_reset();
        repeat (5) drive(1'b1, 1'b0, 1'b0, 64'h0);
        chk("t2_addr_hold", imem_addr, 64'h8);
        chk("t2_head_pc", out_pc, 64'h0);
        chk("t2_head_instr", 64'(out_instr), 64'h0000_0033);
        repeat (4) drive(1'b1, 1'b1, 1'b0, 64'h0);

        repeat (2) drive(1'b1, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 64'h58);
        chk("t3_flushed", 64'(out_valid), 64'h0);
        chk("t3_addr", imem_addr, 64'h58);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t3_pc", out_pc, 64'h58);
        chk("t3_instr", 64'(out_instr), 64'hA001_A001);

        drive(1'b1, 1'b1, 1'b1, 64'h6E);
        chk("t4_addr", imem_addr, 64'h6C);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t4_pc", out_pc, 64'h6C);
        chk("t4_instr", 64'(out_instr), 64'hB001_B001);

        drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t5_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_instr_top", 64'(out_instr), 64'h0000_0033);
        chk("t5_wrap_addr", imem_addr, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t5_pc_wrap", out_pc, 64'h0);
        chk("t5_instr_wrap", 64'(out_instr), 64'h0000_0033);

        repeat (3) drive(1'b1, 1'b0, 1'b0, 64'h0);
        chk("t6_buffered", 64'(out_valid), 64'h1);
        pulse_reset();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        chk("t6_restart_pc", out_pc, 64'h0);
        chk("t6_restart_valid", 64'(out_valid), 64'h1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                fe  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 4) < 3);
                rv  = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0)
                    rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else
                    rpc = 64'($urandom_range(0, 1023));
                drive(fe, rdy, rv, rpc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction_memory in the 64-bit single-cycle RISC-V core.
- Owns the PC and drives the memory address.
- Captures returned instructions with their PC into a small prefetch FIFO.
- Presents them to decode over a valid/ready handshake, with branch/jump redirect and flush.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0, PC value loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- fetch_en  input  1  permits new fetches when high
- imem_addr  output  XLEN  byte address to instruction_memory; equals PC register
- imem_instr  input  32  instruction returned combinationally for imem_addr
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  XLEN  new fetch target
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode accepts head
- out_instr  output  32  head instruction
- out_pc  output  XLEN  PC of head instruction
- fetch_count  output  32  saturating count of instructions delivered (handshakes)

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, FIFO empty, out_valid=0, fetch_count=0.
  - out_instr=32'h00000033 (NOP), out_pc=0.
- imem_addr is combinational from pc; no added latency. An instruction is sampled the same cycle its address is driven.
- push = fetch_en && !redirect_valid && (!full || pop).
- pop = out_valid && out_ready.
- On push:
  - FIFO writes {pc, imem_instr}.
  - pc <= pc+4, modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Redirect (highest priority):
  - FIFO flushed; any pop that cycle still completes (head consumed, counted).
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; misaligned low bits are forced to zero.
  - No push that cycle.
  - First instruction from the new target is visible on out_* one cycle later.
- Full plus pop in the same cycle: push allowed; occupancy unchanged.
- Empty: out_valid=0, out_instr=NOP, out_pc=0. There is no same-cycle bypass; the first instruction after reset appears on cycle 1.
- fetch_en low: pc holds, no pushes; FIFO still drains.
- out_* stable while out_valid && !out_ready; the head cannot change except by redirect flush.
- fetch_count increments on each pop and saturates at 32'hFFFF_FFFF.
- Out-of-range addresses are not checked here; memory returns NOP and it flows through normally.
- Reset mid-stream discards FIFO contents and restarts at RESET_PC.
- States (derived from occupancy): EMPTY, PARTIAL, FULL.
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop.
  - FULL→PARTIAL on pop without push.
  - Any state→EMPTY on redirect or rst.

Decomposition:
- riscv_pkg holds:
  - XLEN, INSTR_W=32, NOP_INSTR=32'h00000033, INSTR_BYTES=4.
  - fetch_entry_t struct {logic [XLEN-1:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH.
  - push/pop/flush inputs; full/empty/count outputs.
  - Pointer wrap with an extra MSB.
- Top holds the PC, push/pop logic and counter.

Test Plan (instruction_memory with its default program):
1. Reset release, fetch_en=1, out_ready=1:
   - Cycle1 out_pc=0, out_instr=00000033.
   - Cycle2 out_pc=4, out_instr=00108093.
   - Cycle3 out_pc=8, out_instr=00208113.
   - fetch_count=3.
2. Backpressure: out_ready=0 for 5 cycles:
   - FIFO fills with 2 entries; imem_addr holds at 8.
   - out_pc stays 0; out_instr stays 00000033.
   - Release → PCs 0,4,8 delivered in order, no loss or duplicate.
3. Redirect: redirect_valid=1, redirect_pc=64'h58 while FIFO holds 2 entries:
   - Next cycle out_valid=0, imem_addr=58.
   - Following cycle out_pc=58, out_instr=A001A001.
4. Misaligned redirect: redirect_pc=64'h6E → imem_addr=6C; then out_instr=B001B001.
5. Wrap: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC → next fetched PCs are ...FFFC then 0; out_instr=00000033 (out-of-range NOP) then 00000033.
6. Async rst pulsed mid-clock with 2 entries buffered:
   - out_valid drops immediately; fetch_count=0.
   - After release, fetch restarts at RESET_PC=0.
